mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Downstream stage of the time-domain 8-bit multiplier. Consumes the multiplier's 8-bit digital product, one per cycle, sums a fixed-length batch of products into a wide accumulator, and presents the dot-product result through a valid/ready handshake to the next stage. Provides the "AC" of the MAC; the time-domain datapath ends at the multiplier, and everything from here on is synchronous digital.

## Interface
Parameters:
- N_TERMS, 8, products summed per batch (≥2)
- ACC_W, 16, accumulator and result width (≥9)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- acc_start  in  1  begin a new batch (sampled in IDLE only)
- prod  in  8  unsigned product from multiplier_8b out
- prod_valid  in  1  prod is a valid term this cycle
- sum  out  ACC_W  batch result, stable while sum_valid=1
- sum_valid  out  1  result available
- sum_ready  in  1  consumer accepts result
- busy  out  1  high in ACCUM and DONE
- ovf  out  1  batch overflowed ACC_W; valid with sum_valid

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: acc_start=1 → ACCUM; acc cleared to 0, term counter cleared to 0, ovf cleared. prod_valid ignored.
- ACCUM: each cycle with prod_valid=1 → acc += zero-extended prod, counter += 1. prod_valid=0 → hold. acc_start ignored.
- When prod_valid=1 and counter = N_TERMS-1: final add; result registered into sum; sum_valid=1; → DONE; counter wraps to 0.
- DONE: sum, ovf and sum_valid held. sum_valid & sum_ready → IDLE, sum_valid=0 next cycle. acc_start and prod_valid ignored.
- Arithmetic: unsigned; a carry out of ACC_W bits on any add sets ovf (sticky for the batch).
- Overflow result per Configuration.
- Reset: acc, counter, sum = 0; sum_valid, busy, ovf = 0; state IDLE. Reset mid-batch discards the partial sum; no result is emitted.

## Timing
- acc_start sampled at edge k → busy=1 from edge k; first term accepted at edge k+1 at earliest.
- Latency: sum_valid rises on the same edge that accepts term N_TERMS; minimum batch = 1 + N_TERMS cycles start to sum_valid.
- sum_ready may be held high in advance; handshake completes on the first edge where both are high; earliest next acc_start is accepted the cycle after.
- No combinational path from any input to any output; all outputs registered.

## Configuration
- MAC_ACC_SAT_EN defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the batch; sum = 2^ACC_W-1; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf still reports the wrap.

## Structure
- Package mac_pkg: state enum (IDLE, ACCUM, DONE), PROD_W=8 constant, default N_TERMS/ACC_W.
- Sub-module mac_acc_adder: combinational ACC_W + 8 adder, outputs next value and carry; applies saturation under MAC_ACC_SAT_EN.
- Counter width $clog2(N_TERMS).

## Test plan
- Reset mid-ACCUM after 3 terms → all outputs 0, IDLE; new batch of 8×prod=1 gives sum=8.
- Batch of 8 terms prod=10..17 back-to-back → sum_valid on the 8th accept edge, sum=108, ovf=0.
- Same batch with prod_valid gaps (alternating) → identical sum=108; busy stays high throughout.
- sum_ready low 5 cycles in DONE, acc_start and prod_valid pulsed → sum held at 108, no state change; ready high → IDLE next cycle.
- ACC_W=9, 8×prod=255 → ovf=1; sum=511 with MAC_ACC_SAT_EN, sum=2040 mod 512 = 504 without.
- acc_start held high permanently, sum_ready=1 → back-to-back batches, one idle cycle between, each result correct.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared definitions for the MAC accumulator slice: the control state
//   encoding, the product width coming from the 8-bit multiplier, and the
//   default batch length and accumulator width.
//   Optional feature macro used by this slice: MAC_ACC_SAT_EN.
package mac_pkg;

   localparam int PROD_W        = 8;
   localparam int N_TERMS_DEF   = 8;
   localparam int ACC_W_DEF     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : mac_pkg

// File: rtl/mac_acc_adder.sv
// mac_acc_adder
//   Combinational accumulate step: adds a zero-extended 8-bit product to the
//   running accumulator and reports the carry out of ACC_W bits.
//   Macro MAC_ACC_SAT_EN: when defined, a carry clamps the result to the
//   all-ones value; otherwise the result wraps modulo 2^ACC_W.
// Ports:
//   acc_i   in  ACC_W   current accumulator value
//   prod_i  in  PROD_W  unsigned product term
//   nxt_o   out ACC_W   next accumulator value
//   carry_o out 1       carry out of the ACC_W-bit add
module mac_acc_adder
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  nxt_o,
   output logic              carry_o
);

   logic [ACC_W:0] raw;

   assign raw     = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
   assign carry_o = raw[ACC_W];

`ifdef MAC_ACC_SAT_EN
   // Once clamped, further adds either carry again or add zero, so the
   // accumulator stays pinned at full scale for the rest of the batch.
   assign nxt_o = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign nxt_o = raw[ACC_W-1:0];
`endif

endmodule : mac_acc_adder

// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Sums a fixed-length batch of N_TERMS unsigned 8-bit products into an
//   ACC_W-bit accumulator and hands the result downstream over a
//   valid/ready handshake. All outputs are registered.
//   Macro MAC_ACC_SAT_EN (see mac_acc_adder) selects saturating overflow.
// Ports:
//   clk        in  1      system clock, rising edge
//   rst        in  1      asynchronous active-low reset
//   acc_start  in  1      begin a new batch (sampled in IDLE only)
//   prod       in  8      unsigned product term
//   prod_valid in  1      prod is a valid term this cycle
//   sum        out ACC_W  batch result, stable while sum_valid
//   sum_valid  out 1      result available
//   sum_ready  in  1      consumer accepts result
//   busy       out 1      high in ACCUM and DONE
//   ovf        out 1      batch overflowed ACC_W, valid with sum_valid
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_start,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              busy,
   output logic              ovf
);

   localparam int                CNT_W    = $clog2(N_TERMS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_TERMS - 1);

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_d;
   logic               carry_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [ACC_W-1:0]   sum_q;
   logic               sum_valid_q;
   logic               busy_q;
   logic               ovf_q;

   mac_acc_adder #(
      .ACC_W (ACC_W)
   ) u_adder (
      .acc_i   (acc_q),
      .prod_i  (prod),
      .nxt_o   (acc_d),
      .carry_o (carry_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (acc_start) begin
                  state_q <= ACCUM;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ACCUM: begin
               if (prod_valid) begin
                  acc_q <= acc_d;
                  // Sticky: any carry during the batch marks the result.
                  ovf_q <= ovf_q | carry_d;
                  if (cnt_q == CNT_LAST) begin
                     // The final term goes straight into sum so the result
                     // appears on the same edge that accepts it.
                     sum_q       <= acc_d;
                     sum_valid_q <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= DONE;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (sum_ready) begin
                  sum_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               sum_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

   logic        clk;
   logic        rst;

   // Instance A: default 8 terms, 16-bit accumulator
   logic        a_start, a_pvalid, a_ready;
   logic [7:0]  a_prod;
   logic [15:0] a_sum;
   logic        a_svalid, a_busy, a_ovf;

   // Instance B: 8 terms, 9-bit accumulator for overflow checks
   logic        b_start, b_pvalid, b_ready;
   logic [7:0]  b_prod;
   logic [8:0]  b_sum;
   logic        b_svalid, b_busy, b_ovf;

   int tests;
   int fails;

   mac_accumulator #(.N_TERMS(8), .ACC_W(16)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .acc_start  (a_start),
      .prod       (a_prod),
      .prod_valid (a_pvalid),
      .sum        (a_sum),
      .sum_valid  (a_svalid),
      .sum_ready  (a_ready),
      .busy       (a_busy),
      .ovf        (a_ovf)
   );

   mac_accumulator #(.N_TERMS(8), .ACC_W(9)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .acc_start  (b_start),
      .prod       (b_prod),
      .prod_valid (b_pvalid),
      .sum        (b_sum),
      .sum_valid  (b_svalid),
      .sum_ready  (b_ready),
      .busy       (b_busy),
      .ovf        (b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // advance one clock, sample 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One batch on instance A; optional one-cycle gap before each term.
   task automatic batch_a(input int base, input int step, input bit gaps,
                          input int exp_sum, input string tag);
      a_start = 1'b1;
      cyc();
      a_start = 1'b0;
      check({tag, "_busy_start"}, a_busy, 1);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            a_pvalid = 1'b0;
            a_prod   = 8'hEE;
            cyc();
            check({tag, "_busy_gap"}, a_busy, 1);
            check({tag, "_nvalid_gap"}, a_svalid, 0);
         end
         a_prod   = 8'(base + i * step);
         a_pvalid = 1'b1;
         cyc();
         if (i < 7) check({tag, "_early_valid"}, a_svalid, 0);
      end
      a_pvalid = 1'b0;
      check({tag, "_valid"}, a_svalid, 1);
      check({tag, "_sum"}, a_sum, exp_sum);
      check({tag, "_ovf"}, a_ovf, 0);
   endtask

   initial begin
      int n;
      tests = 0;
      fails = 0;
      a_start = 0; a_pvalid = 0; a_ready = 0; a_prod = 0;
      b_start = 0; b_pvalid = 0; b_ready = 0; b_prod = 0;
      rst = 1'b0;
      cyc(); cyc();
      check("rst_sum", a_sum, 0);
      check("rst_valid", a_svalid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_ovf", a_ovf, 0);
      rst = 1'b1;
      cyc();

      // Reset in the middle of a batch after 3 terms
      a_start = 1'b1;
      cyc();
      a_start = 1'b0;
      a_prod = 8'd200; a_pvalid = 1'b1;
      cyc(); cyc(); cyc();
      a_pvalid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrst_busy_async", a_busy, 0);
      cyc();
      check("midrst_sum", a_sum, 0);
      check("midrst_valid", a_svalid, 0);
      check("midrst_ovf", a_ovf, 0);
      rst = 1'b1;
      cyc();
      check("midrst_idle", a_busy, 0);
      batch_a(1, 0, 1'b0, 8, "ones");
      a_ready = 1'b1;
      cyc();
      a_ready = 1'b0;
      check("ones_hs_valid", a_svalid, 0);
      check("ones_hs_busy", a_busy, 0);

      // 10..17 back-to-back
      batch_a(10, 1, 1'b0, 108, "b2b");
      a_ready = 1'b1;
      cyc();
      a_ready = 1'b0;
      check("b2b_hs_valid", a_svalid, 0);

      // Same terms with gaps, then hold DONE with ready low
      batch_a(10, 1, 1'b1, 108, "gaps");
      for (int i = 0; i < 5; i++) begin
         a_start  = i[0];
         a_pvalid = ~i[0];
         a_prod   = 8'd99;
         cyc();
         check("hold_sum", a_sum, 108);
         check("hold_valid", a_svalid, 1);
         check("hold_busy", a_busy, 1);
      end
      a_start = 1'b0; a_pvalid = 1'b0;
      a_ready = 1'b1;
      cyc();
      check("rel_valid", a_svalid, 0);
      check("rel_busy", a_busy, 0);

      // Permanent start and ready: back-to-back batches
      a_start = 1'b1; a_ready = 1'b1; a_pvalid = 1'b1; a_prod = 8'd3;
      n = 0;
      while (!a_svalid && n < 20) begin cyc(); n++; end
      check("auto1_seen", a_svalid, 1);
      check("auto1_sum", a_sum, 24);
      a_prod = 8'd5;
      cyc();
      check("auto_idle_busy", a_busy, 0);
      check("auto_idle_valid", a_svalid, 0);
      cyc();
      check("auto_restart_busy", a_busy, 1);
      n = 2;
      while (!a_svalid && n < 30) begin cyc(); n++; end
      check("auto2_seen", a_svalid, 1);
      check("auto2_period", n, 10);
      check("auto2_sum", a_sum, 40);
      a_start = 1'b0; a_pvalid = 1'b0;
      cyc();
      a_ready = 1'b0;

      // Overflow on the 9-bit instance: 8 x 255
      b_start = 1'b1;
      cyc();
      b_start = 1'b0;
      b_prod = 8'd255; b_pvalid = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      b_pvalid = 1'b0;
      check("ovf_valid", b_svalid, 1);
      check("ovf_flag", b_ovf, 1);
`ifdef MAC_ACC_SAT_EN
      check("ovf_sum", b_sum, 511);
`else
      check("ovf_sum", b_sum, 504);
`endif
      b_ready = 1'b1;
      cyc();
      check("ovf_hs", b_svalid, 0);

      // No-overflow batch on the narrow instance clears ovf: 8 x 60 = 480
      b_ready = 1'b0; b_start = 1'b1;
      cyc();
      b_start = 1'b0;
      check("ovf_clear_start", b_ovf, 0);
      b_prod = 8'd60; b_pvalid = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      b_pvalid = 1'b0;
      check("noovf_sum", b_sum, 480);
      check("noovf_flag", b_ovf, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mac_accumulator
